// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one shared round datapath reused over 10 cycles,
// with the key schedule expanded on the fly alongside the state.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign s = sbox_f(a);
endmodule

module aes_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key_in,
  input  logic         final_round,
  output logic [127:0] state_out
);
  logic [127:0] sb, sr, mc;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a(state_in[127-8*i -: 8]), .s(sb[127-8*i -: 8]));
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr = '0;
    mc = '0;
    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

  assign state_out = (final_round ? sr : mc) ^ round_key_in;
endmodule

module aes128_iter_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q, rk_q, rk_next, round_out;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, t, n0, n1, n2, n3;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sub
    aes_sbox u_sbox (.a(rot_w3[31-8*i -: 8]), .s(sub_w3[31-8*i -: 8]));
  end

  assign t       = sub_w3 ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  aes_round u_round (
    .state_in    (state_q),
    .round_key_in(rk_next),
    .final_round (round_q == 4'd10),
    .state_out   (round_out)
  );

  // DONE forwards out_ready so a result can be consumed and a new block taken on one edge.
  assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      rk_q       <= '0;
      ciphertext <= '0;
      rcon_q     <= 8'h01;
      round_q    <= 4'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      state_q   <= plaintext ^ key;
      rk_q      <= key;
      rcon_q    <= 8'h01;
      round_q   <= 4'd1;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      fsm_q     <= ROUND;
    end else begin
      case (fsm_q)
        IDLE: ;
        ROUND: begin
          if (round_q == 4'd0 || round_q > 4'd10) begin
            fsm_q   <= IDLE;
            busy    <= 1'b0;
            round_q <= 4'd0;
          end else begin
            state_q <= round_out;
            rk_q    <= rk_next;
            rcon_q  <= xtime(rcon_q);
            if (round_q == 4'd10) begin
              ciphertext <= round_out;
              out_valid  <= 1'b1;
              busy       <= 1'b0;
              round_q    <= 4'd0;
              fsm_q      <= DONE;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core using FIPS-197 known-answer vectors.

module tb_aes128_iter_core;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_vec = 0;
  int n_err = 0;

  aes128_iter_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .plaintext (plaintext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge with the core idle; leaves the result in DONE.
  task automatic do_block(input logic [127:0] k, input logic [127:0] p, input bit scramble,
                          output logic [127:0] ct, output int lat, output int busy_cnt);
    int n;
    in_valid  = 1'b1;
    key       = k;
    plaintext = p;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (lat < 20) begin
      if (scramble) begin
        key       = {$urandom, $urandom, $urandom, $urandom};
        plaintext = {$urandom, $urandom, $urandom, $urandom};
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    ct = ciphertext;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] ct;
    logic [127:0] outs [2];
    int lat, bc, n_out, vsent;
    int out_cyc [2];
    int acc_cyc [2];
    bit ofire, ifire;
    logic [127:0] ctv;

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ciphertext", ciphertext, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Vector C.1: latency and busy window
    do_block(K1, P1, 1'b0, ct, lat, bc);
    chk("c1_ct", ct, C1);
    chk("c1_latency", lat, 10);
    chk("c1_busy_cycles", bc, 10);
    chk("c1_busy_done", busy, 0);
    consume();
    chk("c1_consumed", out_valid, 0);

    // Vector B plus final round key
    do_block(K2, P2, 1'b0, ct, lat, bc);
    chk("b_ct", ct, C2);
    chk("b_latency", lat, 10);
    chk("b_rk_final", dut.rk_q, RK10);

    // Backpressure: hold result, ignore in_valid pulses
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      key       = {$urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("bp_ct_stable", ciphertext, C2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    consume();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_idle", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_second", out_valid, 0);
    chk("bp_no_busy", busy, 0);

    // Back-to-back through DONE
    in_valid  = 1'b1;
    key       = K1;
    plaintext = P1;
    out_ready = 1'b1;
    n_out = 0;
    vsent = 0;
    acc_cyc = '{0, 0};
    out_cyc = '{0, 0};
    outs = '{'0, '0};
    for (int c = 1; c <= 40 && n_out < 2; c++) begin
      #1;
      ofire = out_valid && out_ready;
      ifire = in_valid && in_ready;
      ctv   = ciphertext;
      @(posedge clk); #1;
      if (ifire && vsent < 2) begin
        if (vsent == 0) begin
          key       = K2;
          plaintext = P2;
        end else begin
          in_valid = 1'b0;
        end
        acc_cyc[vsent] = c;
        vsent++;
      end
      if (ofire) begin
        outs[n_out]    = ctv;
        out_cyc[n_out] = c;
        n_out++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_out_count", n_out, 2);
    chk("b2b_ct1", outs[0], C1);
    chk("b2b_ct2", outs[1], C2);
    chk("b2b_overlap", acc_cyc[1], out_cyc[0]);
    chk("b2b_spacing", out_cyc[1] - out_cyc[0], 11);
    @(posedge clk); #1;
    chk("b2b_idle", in_ready, 1);

    // Reset in the middle of a block
    in_valid  = 1'b1;
    key       = K1;
    plaintext = P1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_round5", dut.round_q, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ct", ciphertext, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_no_output", out_valid, 0);
    do_block(K2, P2, 1'b0, ct, lat, bc);
    chk("mid_after_ct", ct, C2);
    chk("mid_after_latency", lat, 10);
    consume();

    // Inputs scrambled after accept
    do_block(K1, P1, 1'b1, ct, lat, bc);
    chk("scr_ct1", ct, C1);
    consume();
    do_block(K2, P2, 1'b1, ct, lat, bc);
    chk("scr_ct2", ct, C2);
    chk("scr_latency", lat, 10);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
